// File: rtl/race_timer.sv
// race_timer: drag-race referee. Sequences the three-light countdown, times
// both players in ms, flags end of race and waits for the scoreboard's
// acknowledge before re-arming.
module race_timer #(
    parameter int TICK_DIV      = 65000,
    parameter int COUNT_STEP_MS = 1000,
    parameter int MAX_TIME_MS   = 99999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_key,
    input  logic        finish_p1,
    input  logic        finish_p2,
    input  logic        key_press_status,
    output logic [21:0] time_p1,
    output logic [21:0] time_p2,
    output logic        end_game_status,
    output logic        race_active,
    output logic [1:0]  lights
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (COUNT_STEP_MS > 1) ? $clog2(COUNT_STEP_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(COUNT_STEP_MS - 1);
    localparam logic [21:0]   MAX_MS     = 22'(MAX_TIME_MS);

    typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_RACE, S_END} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [SW-1:0] step, step_n;
    logic [21:0]   ms, ms_n;
    logic [21:0]   time_p1_n, time_p2_n;
    logic          done_p1, done_p2, done_p1_n, done_p2_n;
    logic [1:0]    lights_n;
    logic          start_q;
    logic          start_rise;
    logic          tick;

    assign start_rise = start_key & ~start_q;
    assign tick       = (presc == PRESC_LAST);

    // State, counters and all outputs are registered from their next values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            presc           <= '0;
            step            <= '0;
            ms              <= '0;
            done_p1         <= 1'b0;
            done_p2         <= 1'b0;
            // Treat the key as already high so a key held through reset
            // does not look like a fresh press.
            start_q         <= 1'b1;
            time_p1         <= '0;
            time_p2         <= '0;
            lights          <= 2'd0;
            end_game_status <= 1'b0;
            race_active     <= 1'b0;
        end else begin
            state           <= state_n;
            presc           <= presc_n;
            step            <= step_n;
            ms              <= ms_n;
            done_p1         <= done_p1_n;
            done_p2         <= done_p2_n;
            start_q         <= start_key;
            time_p1         <= time_p1_n;
            time_p2         <= time_p2_n;
            lights          <= lights_n;
            end_game_status <= (state_n == S_END);
            race_active     <= (state_n == S_RACE);
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        step_n    = step;
        ms_n      = ms;
        lights_n  = lights;
        done_p1_n = done_p1;
        done_p2_n = done_p2;
        time_p1_n = time_p1;
        time_p2_n = time_p2;
        case (state)
            S_IDLE: begin
                presc_n   = '0;
                step_n    = '0;
                ms_n      = '0;
                lights_n  = 2'd0;
                done_p1_n = 1'b0;
                done_p2_n = 1'b0;
                time_p1_n = '0;
                time_p2_n = '0;
                // Acknowledge must be released first so one keystroke
                // cannot both re-arm and restart.
                if (start_rise && !key_press_status) begin
                    state_n  = S_COUNTDOWN;
                    lights_n = 2'd3;
                end
            end
            S_COUNTDOWN: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (step == STEP_LAST) begin
                        step_n = '0;
                        if (lights == 2'd1) begin
                            // Prescaler wraps to 0 on this tick, so RACE
                            // starts with a fresh ms period.
                            state_n  = S_RACE;
                            lights_n = 2'd0;
                            ms_n     = '0;
                        end else begin
                            lights_n = lights - 2'd1;
                        end
                    end else begin
                        step_n = step + SW'(1);
                    end
                end
            end
            S_RACE: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick && ms != MAX_MS)
                    ms_n = ms + 22'd1;
                // Times mirror the live count until a finish freezes them;
                // a finish on a tick cycle keeps the pre-increment value.
                if (!done_p1 && !finish_p1)
                    time_p1_n = ms_n;
                if (!done_p2 && !finish_p2)
                    time_p2_n = ms_n;
                done_p1_n = done_p1 | finish_p1;
                done_p2_n = done_p2 | finish_p2;
                // At timeout unfinished times already read MAX_MS.
                if ((done_p1_n && done_p2_n) || ms == MAX_MS)
                    state_n = S_END;
            end
            S_END: begin
                if (key_press_status) begin
                    state_n   = S_IDLE;
                    done_p1_n = 1'b0;
                    done_p2_n = 1'b0;
                    time_p1_n = '0;
                    time_p2_n = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_race_timer.sv
// tb_race_timer: directed + randomized checks of race_timer against a
// cycle-count reference model (ms = cycles_in_race / TICK_DIV).
module tb_race_timer;

    localparam int TD    = 4;
    localparam int STEP  = 2;
    localparam int MAXMS = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_key = 1'b1;
    logic        finish_p1 = 1'b0;
    logic        finish_p2 = 1'b0;
    logic        key_press_status = 1'b0;
    logic [21:0] time_p1, time_p2;
    logic        end_game_status, race_active;
    logic [1:0]  lights;

    int total = 0;
    int bad   = 0;

    race_timer #(.TICK_DIV(TD), .COUNT_STEP_MS(STEP), .MAX_TIME_MS(MAXMS)) dut (
        .clk(clk), .reset(reset), .start_key(start_key),
        .finish_p1(finish_p1), .finish_p2(finish_p2),
        .key_press_status(key_press_status),
        .time_p1(time_p1), .time_p2(time_p2),
        .end_game_status(end_game_status), .race_active(race_active),
        .lights(lights)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 countdown, 2 race, 3 end.
    int   m_phase = 0, m_cyc = 0, m_ms = 0, m_t1 = 0, m_t2 = 0;
    logic m_prev = 1'b1, m_d1 = 1'b0, m_d2 = 1'b0;
    int   e_t1 = 0, e_t2 = 0, e_lights = 0;
    logic e_egs = 1'b0, e_ra = 1'b0;

    function automatic int ms_of(input int c);
        return (c / TD > MAXMS) ? MAXMS : c / TD;
    endfunction

    task automatic model_outputs();
        m_ms     = (m_phase == 2) ? ms_of(m_cyc) : 0;
        e_ra     = (m_phase == 2);
        e_egs    = (m_phase == 3);
        e_lights = (m_phase == 1) ? 3 - m_cyc / (STEP * TD) : 0;
        e_t1 = (m_phase == 2) ? (m_d1 ? m_t1 : m_ms) : (m_phase == 3) ? m_t1 : 0;
        e_t2 = (m_phase == 2) ? (m_d2 ? m_t2 : m_ms) : (m_phase == 3) ? m_t2 : 0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_cyc = 0; m_prev = 1'b1;
        m_d1 = 1'b0; m_d2 = 1'b0; m_t1 = 0; m_t2 = 0;
        model_outputs();
    endtask

    task automatic model_update();
        if (!reset) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (start_key && !m_prev && !key_press_status) begin
                       m_phase = 1; m_cyc = 0;
                   end
                1: begin
                    m_cyc++;
                    if (m_cyc == 3 * STEP * TD) begin
                        m_phase = 2; m_cyc = 0; m_d1 = 1'b0; m_d2 = 1'b0;
                    end
                end
                2: begin
                    m_ms = ms_of(m_cyc);
                    if (finish_p1 && !m_d1) begin m_d1 = 1'b1; m_t1 = m_ms; end
                    if (finish_p2 && !m_d2) begin m_d2 = 1'b1; m_t2 = m_ms; end
                    if ((m_d1 && m_d2) || m_ms == MAXMS) begin
                        if (!m_d1) m_t1 = MAXMS;
                        if (!m_d2) m_t2 = MAXMS;
                        m_phase = 3;
                    end else begin
                        m_cyc++;
                    end
                end
                default: if (key_press_status) begin
                    m_phase = 0; m_d1 = 1'b0; m_d2 = 1'b0; m_t1 = 0; m_t2 = 0;
                end
            endcase
            m_prev = start_key;
            model_outputs();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("time_p1", {10'd0, time_p1}, e_t1);
        chk("time_p2", {10'd0, time_p2}, e_t2);
        chk("end_game_status", {31'd0, end_game_status}, {31'd0, e_egs});
        chk("race_active", {31'd0, race_active}, {31'd0, e_ra});
        chk("lights", {30'd0, lights}, e_lights);
    endtask

    // One clock: model samples inputs at the edge, outputs checked mid-cycle.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ms(input int k);
        int n = 0;
        while (!(m_phase == 2 && m_ms == k) && n < 600) begin
            step();
            n++;
        end
        chk("wait_ms_reached", n < 600, 1);
    endtask

    task automatic start_race();
        start_key = 1'b0;
        step();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        chk("countdown_first_light", {30'd0, lights}, 3);
    endtask

    task automatic ack();
        key_press_status = 1'b1;
        step();
        chk("ack_egs_clear", {31'd0, end_game_status}, 0);
        key_press_status = 1'b0;
        step();
    endtask

    task automatic wait_end();
        int n = 0;
        while (m_phase != 3 && n < 400) begin
            step();
            n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, f1, f2;
        model_reset();
        // Reset with start_key held high throughout.
        steps(5);
        chk("reset_time_p1", {10'd0, time_p1}, 0);
        reset = 1'b1;
        steps(5);
        chk("held_key_no_start", {31'd0, race_active}, 0);
        chk("held_key_lights", {30'd0, lights}, 0);

        // Countdown length and ignored finish during countdown.
        start_race();
        n = 0;
        while (!race_active && n < 40) begin
            finish_p1 = (n == 5);
            step();
            n++;
        end
        finish_p1 = 1'b0;
        chk("countdown_len", n, 24);
        chk("race_lights_off", {30'd0, lights}, 0);

        // Normal race: p1 at ms 7, p2 at ms 12.
        wait_ms(7);
        steps($urandom_range(0, 3));
        finish_p1 = 1'b1; step(); finish_p1 = 1'b0;
        chk("p1_latched", {10'd0, time_p1}, 7);
        wait_ms(10);
        chk("p1_frozen", {10'd0, time_p1}, 7);
        chk("p2_live", {10'd0, time_p2}, 10);
        wait_ms(12);
        steps($urandom_range(0, 3));
        finish_p2 = 1'b1; step(); finish_p2 = 1'b0;
        chk("p2_latched", {10'd0, time_p2}, 12);
        chk("normal_end", {31'd0, end_game_status}, 1);
        ack();

        // Simultaneous finish at ms 9.
        start_race();
        wait_ms(9);
        steps($urandom_range(0, 3));
        finish_p1 = 1'b1; finish_p2 = 1'b1; step();
        finish_p1 = 1'b0; finish_p2 = 1'b0;
        chk("sim_p1", {10'd0, time_p1}, 9);
        chk("sim_p2", {10'd0, time_p2}, 9);
        chk("sim_end", {31'd0, end_game_status}, 1);
        ack();

        // Timeout: p1 at ms 20, p2 never.
        start_race();
        wait_ms(20);
        finish_p1 = 1'b1; step(); finish_p1 = 1'b0;
        wait_end();
        chk("to_end", {31'd0, end_game_status}, 1);
        chk("to_p1", {10'd0, time_p1}, 20);
        chk("to_p2", {10'd0, time_p2}, MAXMS);
        steps(5);
        chk("to_p2_held", {10'd0, time_p2}, MAXMS);
        chk("to_inactive", {31'd0, race_active}, 0);

        // Restart: ack, start ignored while ack high, then accepted.
        key_press_status = 1'b1;
        step();
        chk("re_idle_egs", {31'd0, end_game_status}, 0);
        chk("re_idle_time", {10'd0, time_p2}, 0);
        start_key = 1'b1; step(); start_key = 1'b0; step();
        chk("start_while_ack", {30'd0, lights}, 0);
        key_press_status = 1'b0;
        step();
        start_key = 1'b1; step(); start_key = 1'b0;
        chk("start_after_ack", {30'd0, lights}, 3);

        // Asynchronous reset in the middle of a race.
        wait_ms(3);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        chk("async_reset_inactive", {31'd0, race_active}, 0);
        step();
        reset = 1'b1;
        steps(3);

        // Randomized races: level-or-pulse finishes, noise outside RACE.
        for (int k = 0; k < 6; k++) begin
            f1 = $urandom_range(0, 55);
            f2 = $urandom_range(0, 55);
            start_race();
            n = 0;
            while (m_phase != 3 && n < 400) begin
                if (m_phase == 2) begin
                    r = $urandom_range(0, 3);
                    finish_p1 = (m_ms >= f1) && (r != 0);
                    finish_p2 = (m_ms >= f2) && (r != 1);
                end else begin
                    finish_p1 = ($urandom_range(0, 7) == 0);
                    finish_p2 = ($urandom_range(0, 7) == 0);
                end
                step();
                n++;
            end
            finish_p1 = $urandom_range(0, 1);
            finish_p2 = $urandom_range(0, 1);
            step();
            finish_p1 = 1'b0; finish_p2 = 1'b0;
            chk("rand_end", {31'd0, end_game_status}, 1);
            ack();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/race_timer.md
# race_timer

Race referee and timing block for Drag Racing. It sequences the start countdown and measures each player's elapsed race time in milliseconds. It raises `end_game_status` once both players have finished or the race has timed out, then waits for the scoreboard's `key_press_status` acknowledge to re-arm. It drives the `time_p1`, `time_p2` and `end_game_status` inputs of the scoreboard stage and consumes its `key_press_status` output.

## Interface
Parameters:
- `TICK_DIV`, 65000 — clk cycles per 1 ms tick (65 MHz pixel clock).
- `COUNT_STEP_MS`, 1000 — duration of each countdown light, in ms.
- `MAX_TIME_MS`, 99999 — race timeout and saturation value, in ms; must be < 2^22.

Ports:
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_key`  in  1  start request, level from keyboard decoder.
- `finish_p1`  in  1  player 1 crossed finish line, level or pulse.
- `finish_p2`  in  1  player 2 crossed finish line, level or pulse.
- `key_press_status`  in  1  restart acknowledge from scoreboard.
- `time_p1`  out  22  player 1 time in ms.
- `time_p2`  out  22  player 2 time in ms.
- `end_game_status`  out  1  result valid; scoreboard shows the winner.
- `race_active`  out  1  cars may move.
- `lights`  out  2  countdown light value: 3, 2, 1, 0 = off/go.

## Operation
- FSM states:
  - IDLE → COUNTDOWN on a `start_key` rising edge while `key_press_status` = 0.
  - COUNTDOWN → RACE after 3 × `COUNT_STEP_MS` ticks.
  - RACE → END when both players have finished, or when the ms counter reaches `MAX_TIME_MS`.
  - END → IDLE when `key_press_status` = 1.
- Rising edge of `start_key` is detected with one registered copy of the input.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 and emits a 1-cycle tick on wrap.
  - Cleared on entry to COUNTDOWN and to RACE.
- COUNTDOWN: `lights` = 3 for the first `COUNT_STEP_MS` ticks, then 2, then 1. The step counter is cleared on state entry.
- RACE: `race_active` = 1, `lights` = 0. A 22-bit ms counter starts at 0 on entry and increments per tick.
- Finish latch per player:
  - The first sampled high on `finish_pX` in RACE sets `done_pX` and freezes `time_pX` at the current ms count.
  - Later pulses are ignored.
- `time_pX` tracks the live ms count until `done_pX` is set; it is 0 in IDLE and COUNTDOWN.
- Timeout: when the ms count equals `MAX_TIME_MS`, each unfinished player's time is set to `MAX_TIME_MS` and the FSM enters END. The counter never exceeds `MAX_TIME_MS`.
- END:
  - `end_game_status` = 1, `race_active` = 0, times held.
  - Equal times are legal; the scoreboard shows no winner.
- IDLE: times cleared to 0, `done` flags cleared, `end_game_status` = 0, `lights` = 0.
- `finish_pX` in IDLE, COUNTDOWN or END is ignored. There is no false-start penalty.
- `start_key` outside IDLE is ignored.

## Timing
- Reset (asynchronous assert, synchronous release) puts the block in IDLE with every output 0 and all counters cleared. Reset asserted mid-race aborts immediately.
- All outputs are registered; every state change is visible one cycle after its cause is sampled.
- COUNTDOWN length is exactly 3 × `COUNT_STEP_MS` × `TICK_DIV` cycles from the first COUNTDOWN cycle to the first RACE cycle.
- The first ms increment occurs `TICK_DIV` cycles after RACE entry.
- `finish_pX` sampled high in cycle N latches the ms value held in cycle N.
- If a tick and a finish occur in the same cycle, the pre-increment value is latched.
- Simultaneous finishes in the same cycle:
  - Both players latch the identical value.
  - END is entered in cycle N+1, with `end_game_status` = 1 from cycle N+1.
- Timeout is checked after the increment; a finish in the cycle the count reaches `MAX_TIME_MS` latches `MAX_TIME_MS`.
- `key_press_status` stays high for at least one cycle after END is left. IDLE requires it to be low before accepting a start, so a single keystroke cannot both restart and re-arm.

## Test plan
All scenarios use `TICK_DIV`=4, `COUNT_STEP_MS`=2, `MAX_TIME_MS`=50.
- Reset: hold `reset`=0 for 5 cycles, then release → all outputs 0, no start without a `start_key` edge; `start_key` held high from reset does not start the race.
- Countdown: `start_key` rising edge → `lights` reads 3, 2, 1 for 8 cycles each, then `race_active`=1 and `lights`=0 exactly 24 cycles after COUNTDOWN entry; a `finish_p1` pulse during COUNTDOWN is ignored.
- Normal race:
  - `finish_p1` pulses at ms 7, `finish_p2` at ms 12 → `time_p1`=7 frozen while `time_p2` keeps counting.
  - Then `time_p2`=12 and `end_game_status`=1 one cycle after the second finish.
- Simultaneous finish: both pulses in the same cycle at ms 9 → `time_p1`=`time_p2`=9, END the next cycle.
- Timeout: `finish_p1` at ms 20, `finish_p2` never → at ms 50 `time_p2`=50, `time_p1`=20, `end_game_status`=1, and the counter stops.
- Restart:
  - In END, assert `key_press_status`=1 → next cycle IDLE with times 0 and `end_game_status`=0.
  - A `start_key` edge while `key_press_status` is still 1 is ignored; a new edge after it drops starts a new COUNTDOWN.
  - Reset pulsed mid-RACE returns to IDLE asynchronously.
